mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, fixed-latency memory between the instruction-fetch requester and the data load/store requester of the pipelined core. It arbitrates, latches the winning request, drives the memory for a programmable number of wait cycles, returns read data with a one-cycle valid pulse and raises per-requester stall signals for the hazard logic. It sits between the IF/MEM stages and a unified SRAM.

## Interface
- ADDR_W, 9, address width (matches PC and data-memory address width)
- DATA_W, 32, data width
- WAIT_CYC, 2, memory access cycles per transfer; legal range 1..15
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request, held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted (one-cycle pulse)
- if_rvalid  out  1  fetch data valid (one-cycle pulse)
- if_rdata  out  DATA_W  fetch data
- if_stall  out  1  fetch pending and not completing this cycle
- dm_req  in  1  data request, held with payload until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_func3  in  3  access size/sign code, passed through
- dm_gnt  out  1  data request accepted (one-cycle pulse)
- dm_rvalid  out  1  load data valid / store done (one-cycle pulse)
- dm_rdata  out  DATA_W  load data
- dm_stall  out  1  data pending and not completing this cycle
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_func3  out  3  memory size code
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Arbitration happens in IDLE and RESP: if any req, winner gets gnt combinationally that cycle; payload and owner latched at the edge; next state ACCESS, counter loaded with WAIT_CYC-1. No req: IDLE→IDLE, RESP→IDLE.
- Default priority: DM beats IF on simultaneous requests. IF starvation under continuous DM requests is permitted.
- ACCESS: mem_en=1, mem_we/addr/wdata/func3 from latched registers (mem_we=0 for fetch). Counter decrements each cycle; at counter 0 the edge captures mem_rdata into the read register and moves to RESP.
- RESP: owner's rvalid=1 for exactly one cycle; mem_en=0; if_rdata and dm_rdata both driven from the read register (meaningful only with rvalid). Store completion also pulses dm_rvalid; dm_rdata is don't-care.
- Request dropped before gnt is withdrawn; no access. Payload may change after gnt.
- if_stall = if_req & ~if_rvalid; dm_stall = dm_req & ~dm_rvalid.

## Timing
- Reset (asynchronous, active-low): state IDLE, counter 0, latched payload 0, read register 0, last-owner = IF; all outputs 0 except gnt, which may go high combinationally in IDLE. In-flight access aborted: mem_en drops immediately, no rvalid issued.
- Latency: gnt at cycle 0 → mem_en cycles 1..WAIT_CYC → rvalid at cycle WAIT_CYC+1.
- Back-to-back throughput: one transfer per WAIT_CYC+1 cycles (new gnt in RESP cycle).
- Counter is 4 bits; WAIT_CYC outside 1..15 is an elaboration error.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not granted last; last-owner updates on every gnt; reset value IF, so the first tie goes to DM. Single requests are granted unconditionally.
- Undefined: fixed DM-over-IF priority; no last-owner register.

## Test plan
- WAIT_CYC=2, if_req with if_addr=0x010, mem_rdata=0x00500093 → if_gnt cycle 0, mem_en cycles 1–2, if_rvalid with if_rdata=0x00500093 at cycle 3.
- dm_req store dm_addr=0x040, dm_wdata=0xDEADBEEF, dm_func3=3'b010 → mem_we=1, mem_addr=0x040, mem_wdata=0xDEADBEEF for 2 cycles, dm_rvalid at cycle 3, if_rvalid stays 0.
- if_req and dm_req both held for two transfers, fixed priority → two DM grants, IF not granted, if_stall=1 throughout; with MEM_ARB_ROUND_ROBIN_EN → DM, then IF.
- Continuous dm_req loads → gnt in each RESP cycle, one dm_rvalid every 3 cycles.
- reset asserted low during second ACCESS cycle → mem_en=0 immediately, no rvalid, busy=0; after release a new if_req completes normally.
- if_req dropped while DM owns the port → no fetch access; if_gnt never asserted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port, fixed-latency SRAM between the
//               instruction-fetch and data load/store requesters. Grants one
//               requester, holds the memory for WAIT_CYC cycles, then returns
//               read data with a one-cycle valid pulse. Stall outputs feed
//               the pipeline hazard logic.
// Options     : MEM_ARB_ROUND_ROBIN_EN - alternate grants on simultaneous
//               requests (default: data beats fetch).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_func3,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Counter counts down to zero, so WAIT_CYC cycles means a load of WAIT_CYC-1.
  localparam logic [3:0] c_cnt_load = 4'(WAIT_CYC - 1);
  // Instruction fetches are always full-word reads.
  localparam logic [2:0] c_func3_word = 3'b010;

  generate
    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_wait_cyc_range
      $error("mem_port_arbiter: WAIT_CYC must be within 1..15");
    end
  endgenerate

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_owner_dm;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_func3;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_arb_slot;
  logic                w_grant_dm;
  logic                w_grant_if;

  // New grants are only possible while the memory is not being accessed.
  assign w_arb_slot = (r_state == ST_IDLE) || (r_state == ST_RESP);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_dm;

  // On a tie, the requester that did not win last time goes first.
  assign w_grant_dm = w_arb_slot & dm_req & (~if_req | ~r_last_dm);

  // Remember which requester received the most recent grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_dm <= 1'b0;
    end else if (w_grant_dm || w_grant_if) begin
      r_last_dm <= w_grant_dm;
    end
  end
`else
  // Data accesses always win a tie; fetch may starve under continuous traffic.
  assign w_grant_dm = w_arb_slot & dm_req;
`endif

  assign w_grant_if = w_arb_slot & if_req & ~w_grant_dm;

  // Main sequencer: latch the winner, count the access, capture read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_func3    <= 3'b000;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_grant_dm || w_grant_if) begin
            r_state    <= ST_ACCESS;
            r_cnt      <= c_cnt_load;
            r_owner_dm <= w_grant_dm;
            if (w_grant_dm) begin
              r_we    <= dm_we;
              r_addr  <= dm_addr;
              r_wdata <= dm_wdata;
              r_func3 <= dm_func3;
            end else begin
              r_we    <= 1'b0;
              r_addr  <= if_addr;
              r_wdata <= '0;
              r_func3 <= c_func3_word;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= mem_rdata;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt    = w_grant_if;
  assign dm_gnt    = w_grant_dm;

  assign mem_en    = (r_state == ST_ACCESS);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_func3 = r_func3;

  assign if_rvalid = (r_state == ST_RESP) & ~r_owner_dm;
  assign dm_rvalid = (r_state == ST_RESP) &  r_owner_dm;
  assign if_rdata  = r_rdata;
  assign dm_rdata  = r_rdata;

  assign if_stall  = if_req & ~if_rvalid;
  assign dm_stall  = dm_req & ~dm_rvalid;

  assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and randomized stimulus for mem_port_arbiter with a
//               transaction-timing reference model and a behavioural SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid, if_stall;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [2:0]    dm_func3 = 3'b000;
  logic          dm_gnt, dm_rvalid, dm_stall;
  logic [DW-1:0] dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  logic [DW-1:0] sram    [512];
  logic [DW-1:0] ref_mem [512];

  assign mem_rdata = sram[mem_addr];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_func3(dm_func3), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Reference model: one transaction at a time, described by its grant cycle.
  int            cyc = 0;
  bit            act = 1'b0;
  int            g = 0;
  bit            o_dm = 1'b0;
  bit            t_we = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0;
  logic [2:0]    t_f3 = 3'b000;
  bit            last_dm = 1'b0;
  bit            e_if_gnt, e_dm_gnt;
  int            n_chk = 0;
  int            n_fail = 0;
  int            if_gnt_seen = 0;
  int            dm_gnt_seen = 0;
  int            dm_rv_seen = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: predict, compare mid-cycle, advance the model.
  task automatic step();
    bit            e_acc, e_rsp;
    logic [DW-1:0] e_rd;
    bit            s_en, s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    if (act && cyc > g + W + 1) act = 1'b0;
    e_acc = act && (cyc > g) && (cyc <= g + W);
    e_rsp = act && (cyc == g + W + 1);
    e_dm_gnt = 1'b0;
    e_if_gnt = 1'b0;
    if (!e_acc) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      e_dm_gnt = dm_req && (!if_req || !last_dm);
`else
      e_dm_gnt = dm_req;
`endif
      e_if_gnt = if_req && !e_dm_gnt;
    end
    e_rd = ref_mem[t_addr];
    @(negedge clk);
    chk1("if_gnt", if_gnt, e_if_gnt);
    chk1("dm_gnt", dm_gnt, e_dm_gnt);
    chk1("mem_en", mem_en, e_acc);
    chk1("busy", busy, e_acc || e_rsp);
    chk1("if_rvalid", if_rvalid, e_rsp && !o_dm);
    chk1("dm_rvalid", dm_rvalid, e_rsp && o_dm);
    chk1("if_stall", if_stall, if_req && !(e_rsp && !o_dm));
    chk1("dm_stall", dm_stall, dm_req && !(e_rsp && o_dm));
    if (e_acc) begin
      chk1("mem_we", mem_we, t_we);
      chkw("mem_addr", 32'(mem_addr), 32'(t_addr));
      if (t_we) chkw("mem_wdata", mem_wdata, t_wdata);
      if (o_dm) chkw("mem_func3", 32'(mem_func3), 32'(t_f3));
    end
    if (e_rsp && !o_dm) chkw("if_rdata", if_rdata, e_rd);
    if (e_rsp && o_dm && !t_we) chkw("dm_rdata", dm_rdata, e_rd);
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
    if (if_gnt) if_gnt_seen++;
    if (dm_gnt) dm_gnt_seen++;
    if (dm_rvalid) dm_rv_seen++;
    @(posedge clk);
    if (e_rsp && o_dm && t_we) ref_mem[t_addr] = t_wdata;
    if (e_dm_gnt || e_if_gnt) begin
      act     = 1'b1;
      g       = cyc;
      o_dm    = e_dm_gnt;
      last_dm = e_dm_gnt;
      t_we    = e_dm_gnt && dm_we;
      t_addr  = e_dm_gnt ? dm_addr : if_addr;
      t_wdata = dm_wdata;
      t_f3    = dm_func3;
    end
    cyc++;
    #1;
    if (s_en && s_we) sram[s_addr] = s_wd;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_counts();
    if_gnt_seen = 0; dm_gnt_seen = 0; dm_rv_seen = 0;
  endtask

  // Reset mid-cycle: everything must collapse at once, without a clock edge.
  task automatic mid_reset();
    if_req = 1'b0; dm_req = 1'b0;
    reset = 1'b0;
    #1;
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_dm_rvalid", dm_rvalid, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chkw("rst_if_rdata", if_rdata, 32'h0);
    chkw("rst_mem_addr", 32'(mem_addr), 32'h0);
    act = 1'b0; last_dm = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk1("rst_held_if_rvalid", if_rvalid, 1'b0);
    reset = 1'b1;
    cyc += 2;
  endtask

  bit hold_if, hold_dm;

  initial begin
    for (int i = 0; i < 512; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[9'h010] = 32'h00500093; ref_mem[9'h010] = 32'h00500093;

    // Reset state
    #1;
    chk1("reset_mem_en", mem_en, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_if_gnt", if_gnt, 1'b0);
    chk1("reset_dm_gnt", dm_gnt, 1'b0);
    chkw("reset_dm_rdata", dm_rdata, 32'h0);
    chkw("reset_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Both requesters held across two transfers
    clear_counts();
    if_req = 1'b1; if_addr = 9'h011;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h012; dm_func3 = 3'b010;
    run(2 * (W + 1));
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chkw("tie_dm_grants", dm_gnt_seen, 1);
    chkw("tie_if_grants", if_gnt_seen, 1);
`else
    chkw("tie_dm_grants", dm_gnt_seen, 2);
    chkw("tie_if_grants", if_gnt_seen, 0);
`endif
    if_req = 1'b0; dm_req = 1'b0;
    run(W + 2);

    // Single fetch with known instruction word
    if_req = 1'b1; if_addr = 9'h010;
    step();
    if_req = 1'b0;
    run(W);
    @(negedge clk);
    chk1("fetch_rvalid_c3", if_rvalid, 1'b1);
    chkw("fetch_rdata_c3", if_rdata, 32'h00500093);
    @(posedge clk); #1;
    cyc++; act = 1'b0;
    run(1);

    // Store then load back the same word
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 9'h040; dm_wdata = 32'hDEADBEEF; dm_func3 = 3'b010;
    step();
    dm_req = 1'b0;
    run(W + 1);
    dm_req = 1'b1; dm_we = 1'b0;
    step();
    dm_req = 1'b0;
    run(W);
    @(negedge clk);
    chkw("load_back_rdata", dm_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    cyc++; act = 1'b0;

    // Continuous loads: one grant per RESP cycle
    clear_counts();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h041;
    for (int k = 0; k < 10; k++) begin
      step();
      if (e_dm_gnt) dm_addr = 9'($urandom_range(0, 63));
    end
    chkw("stream_rvalids", dm_rv_seen, 3);
    chkw("stream_grants", dm_gnt_seen, 4);
    dm_req = 1'b0;
    run(W + 2);

    // Reset during the second access cycle, then a clean fetch
    if_req = 1'b1; if_addr = 9'h020;
    step();
    if_req = 1'b0;
    step();
    mid_reset();
    if_req = 1'b1; if_addr = 9'h010;
    step();
    if_req = 1'b0;
    run(W + 2);

    // Fetch request withdrawn while data owns the port
    clear_counts();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 9'h050;
    step();
    dm_req = 1'b0;
    if_req = 1'b1; if_addr = 9'h060;
    step();
    if_req = 1'b0;
    run(W + 1);
    chkw("withdrawn_if_grants", if_gnt_seen, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step();
      hold_if = if_req && !e_if_gnt && ($urandom_range(0, 15) != 0);
      hold_dm = dm_req && !e_dm_gnt && ($urandom_range(0, 15) != 0);
      if (!hold_if) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = 9'($urandom_range(0, 15));
      end
      if (!hold_dm) begin
        dm_req   = 1'($urandom_range(0, 1));
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 9'($urandom_range(0, 15));
        dm_wdata = $urandom;
        dm_func3 = 3'($urandom_range(0, 7));
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    run(W + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
